// File: rtl/scrambler_par.sv
// scrambler_par: parametrised additive scrambler/descrambler, DATA_W bits per accepted beat,
// valid/ready flow control with one output register. `define SCRAMBLER_PAR_BYPASS_EN adds bypass_i.
module scrambler_par #(
  parameter int unsigned       LFSR_W = 12,
  parameter logic [LFSR_W-1:0] TAPS   = 12'h902,
  parameter logic [LFSR_W-1:0] SEED   = 12'h14D,
  parameter int unsigned       DATA_W = 4
) (
  input  logic              clk_i,
  input  logic              rstn_i,
  input  logic              valid_i,
  output logic              ready_o,
  input  logic              sof_i,
`ifdef SCRAMBLER_PAR_BYPASS_EN
  input  logic              bypass_i,
`endif
  input  logic [DATA_W-1:0] data_i,
  output logic              valid_o,
  input  logic              ready_i,
  output logic              sof_o,
  output logic [DATA_W-1:0] data_o,
  output logic [LFSR_W-1:0] lfsr_o
);

  logic [LFSR_W-1:0] lfsr_q;
  logic [LFSR_W-1:0] lfsr_work;
  logic [LFSR_W-1:0] lfsr_nxt;
  logic [DATA_W-1:0] key;
  logic [DATA_W-1:0] key_eff;
  logic              accept;

  assign ready_o = ~valid_o | ready_i;
  assign accept  = valid_i & ready_o;
  assign lfsr_o  = lfsr_q;

  // Unrolled DATA_W-step shift; the first key bit in time ends up in key[DATA_W-1]
  always_comb begin
    lfsr_work = sof_i ? SEED : lfsr_q;
    key       = '0;
    for (int unsigned k = 0; k < DATA_W; k++) begin
      key       = (key << 1) | DATA_W'(lfsr_work[LFSR_W-1]);
      lfsr_work = {lfsr_work[LFSR_W-2:0], ^(lfsr_work & TAPS)};
    end
    lfsr_nxt = lfsr_work;
  end

`ifdef SCRAMBLER_PAR_BYPASS_EN
  // Bypass only masks the key; the LFSR still steps so alignment survives
  assign key_eff = bypass_i ? '0 : key;
`else
  assign key_eff = key;
`endif

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      lfsr_q  <= SEED;
      valid_o <= 1'b0;
      sof_o   <= 1'b0;
      data_o  <= '0;
    end else if (accept) begin
      lfsr_q  <= lfsr_nxt;
      valid_o <= 1'b1;
      sof_o   <= sof_i;
      data_o  <= data_i ^ key_eff;
    end else if (ready_i) begin
      valid_o <= 1'b0;
    end
  end

endmodule

// File: tb/tb_scrambler_par.sv
// tb_scrambler_par: randomized self-checking bench for scrambler_par against a keystream model.
// Honours SCRAMBLER_PAR_BYPASS_EN when defined.
module tb_scrambler_par;

  localparam int unsigned LW     = 12;
  localparam int unsigned TAPS_M = 32'h902;
  localparam int unsigned SEED_M = 32'h14D;
  localparam int unsigned MASK   = 32'hFFF;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // main scrambler
  logic        valid_i, sof_i, ready_i_tb, chain, dut_ready_i;
  logic [3:0]  data_i;
  logic        ready_o, valid_o, sof_o;
  logic [3:0]  data_o;
  logic [11:0] lfsr_o;
`ifdef SCRAMBLER_PAR_BYPASS_EN
  logic        bypass;
`endif

  // descrambler fed from the main scrambler
  logic        d_valid_i, d_ready_o, d_valid_o, d_ready_i, d_sof_o;
  logic [3:0]  d_data_o;
  logic [11:0] d_lfsr_o;

  // 1-bit instance
  logic        b_valid_i, b_ready_o, b_valid_o, b_sof_o;
  logic [0:0]  b_data_i, b_data_o;
  logic [11:0] b_lfsr_o;

  assign dut_ready_i = chain ? d_ready_o : ready_i_tb;
  assign d_valid_i   = chain & valid_o;

  scrambler_par #(.LFSR_W(12), .TAPS(12'h902), .SEED(12'h14D), .DATA_W(4)) u_dut (
    .clk_i(clk), .rstn_i(rstn), .valid_i(valid_i), .ready_o(ready_o), .sof_i(sof_i),
`ifdef SCRAMBLER_PAR_BYPASS_EN
    .bypass_i(bypass),
`endif
    .data_i(data_i), .valid_o(valid_o), .ready_i(dut_ready_i), .sof_o(sof_o),
    .data_o(data_o), .lfsr_o(lfsr_o)
  );

  scrambler_par #(.LFSR_W(12), .TAPS(12'h902), .SEED(12'h14D), .DATA_W(4)) u_desc (
    .clk_i(clk), .rstn_i(rstn), .valid_i(d_valid_i), .ready_o(d_ready_o), .sof_i(sof_o),
`ifdef SCRAMBLER_PAR_BYPASS_EN
    .bypass_i(1'b0),
`endif
    .data_i(data_o), .valid_o(d_valid_o), .ready_i(d_ready_i), .sof_o(d_sof_o),
    .data_o(d_data_o), .lfsr_o(d_lfsr_o)
  );

  scrambler_par #(.LFSR_W(12), .TAPS(12'h902), .SEED(12'h14D), .DATA_W(1)) u_bit (
    .clk_i(clk), .rstn_i(rstn), .valid_i(b_valid_i), .ready_o(b_ready_o), .sof_i(1'b0),
`ifdef SCRAMBLER_PAR_BYPASS_EN
    .bypass_i(1'b0),
`endif
    .data_i(b_data_i), .valid_o(b_valid_o), .ready_i(1'b1), .sof_o(b_sof_o),
    .data_o(b_data_o), .lfsr_o(b_lfsr_o)
  );

  // Reference: Fibonacci LFSR stepped n times; first key bit in time lands in the MSB of key
  function automatic void mbeat(input int unsigned st, input int unsigned n,
                                output int unsigned key, output int unsigned nst);
    int unsigned fb;
    key = 0;
    nst = st;
    for (int unsigned k = 0; k < n; k++) begin
      key = (key << 1) | ((nst >> (LW - 1)) & 1);
      fb  = $countones(nst & TAPS_M) % 2;
      nst = ((nst << 1) | fb) & MASK;
    end
  endfunction

  int unsigned m4, mb;

  task automatic do_reset;
    @(posedge clk); #1;
    rstn = 1'b0;
    valid_i = 1'b0; sof_i = 1'b0; data_i = '0; ready_i_tb = 1'b1; chain = 1'b0;
    d_ready_i = 1'b1; b_valid_i = 1'b0; b_data_i = '0;
`ifdef SCRAMBLER_PAR_BYPASS_EN
    bypass = 1'b0;
`endif
    #2;
    rstn = 1'b1;
    m4 = SEED_M;
    mb = SEED_M;
  endtask

  task automatic test_reset;
    do_reset;
    @(posedge clk); #1;
    rstn = 1'b0;
    #1;
    checks++;
    if (lfsr_o !== 12'h14D) begin errors++; $display("FAIL reset_lfsr: got %h expected 14d", lfsr_o); end
    checks++;
    if (valid_o !== 1'b0 || sof_o !== 1'b0 || data_o !== 4'h0)
      begin errors++; $display("FAIL reset_out: got v=%b s=%b d=%h expected 0 0 0", valid_o, sof_o, data_o); end
    checks++;
    if (ready_o !== 1'b1 || b_ready_o !== 1'b1)
      begin errors++; $display("FAIL reset_ready: got %b %b expected 1 1", ready_o, b_ready_o); end
    checks++;
    if (b_lfsr_o !== 12'h14D || d_lfsr_o !== 12'h14D || b_valid_o !== 1'b0 || b_sof_o !== 1'b0)
      begin errors++; $display("FAIL reset_others: got %h %h %b %b expected 14d 14d 0 0", b_lfsr_o, d_lfsr_o, b_valid_o, b_sof_o); end
    rstn = 1'b1;
  endtask

  task automatic test_stream;
    int unsigned key, st, d, expv;
    logic s;
    do_reset;
    valid_i = 1'b1;
    for (int i = 0; i < 24; i++) begin
      d = (i < 3) ? 0 : $urandom_range(0, 15);
      s = (i == 2) || (i >= 3 && $urandom_range(0, 3) == 0);
      st = s ? SEED_M : m4;
      mbeat(st, 4, key, m4);
      expv = d ^ key;
      sof_i = s; data_i = d[3:0];
      @(posedge clk); #1;
      checks++;
      if (valid_o !== 1'b1 || data_o !== expv[3:0] || sof_o !== s)
        begin errors++; $display("FAIL stream_beat%0d: got v=%b d=%h s=%b expected 1 %h %b", i, valid_o, data_o, sof_o, expv[3:0], s); end
      checks++;
      if (lfsr_o !== m4[11:0])
        begin errors++; $display("FAIL stream_lfsr%0d: got %h expected %h", i, lfsr_o, m4[11:0]); end
      if (i == 0 || i == 2) begin
        checks++;
        if (data_o !== 4'h1) begin errors++; $display("FAIL stream_first%0d: got %h expected 1", i, data_o); end
      end
    end
    valid_i = 1'b0; sof_i = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (valid_o !== 1'b0 || data_o !== expv[3:0] || lfsr_o !== m4[11:0])
      begin errors++; $display("FAIL stream_drain: got v=%b d=%h l=%h expected 0 %h %h", valid_o, data_o, lfsr_o, expv[3:0], m4[11:0]); end
  endtask

  task automatic test_bit;
    logic [11:0] exp_l[3];
    logic        exp_b[4];
    int unsigned key, d;
    exp_l = '{12'h29B, 12'h537, 12'hA6E};
    exp_b = '{1'b0, 1'b0, 1'b0, 1'b1};
    do_reset;
    b_valid_i = 1'b1;
    for (int i = 0; i < 12; i++) begin
      d = (i < 4) ? 0 : $urandom_range(0, 1);
      b_data_i = d[0:0];
      mbeat(mb, 1, key, mb);
      @(posedge clk); #1;
      checks++;
      if (b_valid_o !== 1'b1 || b_data_o[0] !== (d[0] ^ key[0]) || b_lfsr_o !== mb[11:0])
        begin errors++; $display("FAIL bit_beat%0d: got v=%b d=%b l=%h expected 1 %b %h", i, b_valid_o, b_data_o, b_lfsr_o, d[0] ^ key[0], mb[11:0]); end
      if (i < 4) begin
        checks++;
        if (b_data_o[0] !== exp_b[i]) begin errors++; $display("FAIL bit_legacy%0d: got %b expected %b", i, b_data_o, exp_b[i]); end
      end
      if (i < 3) begin
        checks++;
        if (b_lfsr_o !== exp_l[i]) begin errors++; $display("FAIL bit_lfsr%0d: got %h expected %h", i, b_lfsr_o, exp_l[i]); end
      end
    end
    b_valid_i = 1'b0;
  endtask

  task automatic test_backpressure;
    int unsigned key, e1, d2, e2;
    do_reset;
    valid_i = 1'b1; sof_i = 1'b0; data_i = 4'h0;
    mbeat(m4, 4, key, m4);
    e1 = key;
    @(posedge clk); #1;
    checks++;
    if (valid_o !== 1'b1 || data_o !== e1[3:0] || data_o !== 4'h1)
      begin errors++; $display("FAIL bp_first: got v=%b d=%h expected 1 1", valid_o, data_o); end
    ready_i_tb = 1'b0;
    d2 = $urandom_range(0, 15);
    data_i = d2[3:0]; sof_i = 1'b1;
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++;
      if (ready_o !== 1'b0) begin errors++; $display("FAIL bp_ready%0d: got %b expected 0", c, ready_o); end
      @(posedge clk); #1;
      checks++;
      if (valid_o !== 1'b1 || data_o !== e1[3:0] || lfsr_o !== m4[11:0] || sof_o !== 1'b0)
        begin errors++; $display("FAIL bp_stall%0d: got v=%b d=%h l=%h s=%b expected 1 %h %h 0", c, valid_o, data_o, lfsr_o, sof_o, e1[3:0], m4[11:0]); end
    end
    sof_i = 1'b0; ready_i_tb = 1'b1;
    #1;
    checks++;
    if (ready_o !== 1'b1) begin errors++; $display("FAIL bp_release_ready: got %b expected 1", ready_o); end
    mbeat(m4, 4, key, m4);
    e2 = d2 ^ key;
    @(posedge clk); #1;
    checks++;
    if (valid_o !== 1'b1 || data_o !== e2[3:0] || lfsr_o !== m4[11:0])
      begin errors++; $display("FAIL bp_resume: got v=%b d=%h l=%h expected 1 %h %h", valid_o, data_o, lfsr_o, e2[3:0], m4[11:0]); end
    // sof without valid must not reseed
    valid_i = 1'b0; sof_i = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (valid_o !== 1'b0 || data_o !== e2[3:0] || lfsr_o !== m4[11:0])
      begin errors++; $display("FAIL bp_sof_novalid: got v=%b d=%h l=%h expected 0 %h %h", valid_o, data_o, lfsr_o, e2[3:0], m4[11:0]); end
    sof_i = 1'b0; valid_i = 1'b1; data_i = 4'h0;
    mbeat(m4, 4, key, m4);
    @(posedge clk); #1;
    checks++;
    if (data_o !== key[3:0] || lfsr_o !== m4[11:0])
      begin errors++; $display("FAIL bp_after_sof: got d=%h l=%h expected %h %h", data_o, lfsr_o, key[3:0], m4[11:0]); end
    valid_i = 1'b0;
  endtask

  task automatic test_loopback;
    logic [3:0] q_d[$];
    logic       q_s[$];
    int sent, got, cyc;
    logic acc, dacc;
    do_reset;
    chain = 1'b1;
    sent = 0; got = 0; cyc = 0;
    while (got < 1000 && cyc < 8000) begin
      if (sent < 1000) begin
        valid_i = ($urandom_range(0, 3) != 0);
        data_i  = 4'($urandom_range(0, 15));
        sof_i   = (sent == 0);
      end else begin
        valid_i = 1'b0; sof_i = 1'b0;
      end
      d_ready_i = ($urandom_range(0, 3) != 0);
      #1;
      acc  = valid_i & ready_o;
      dacc = d_valid_o & d_ready_i;
      if (acc) begin q_d.push_back(data_i); q_s.push_back(sof_i); sent++; end
      if (dacc) begin
        checks++;
        if (q_d.size() == 0) begin
          errors++; $display("FAIL loop_extra: got unexpected beat %h expected none", d_data_o);
        end else begin
          if (d_data_o !== q_d[0] || d_sof_o !== q_s[0])
            begin errors++; $display("FAIL loop_beat%0d: got d=%h s=%b expected %h %b", got, d_data_o, d_sof_o, q_d[0], q_s[0]); end
          void'(q_d.pop_front()); void'(q_s.pop_front());
        end
        got++;
      end
      @(posedge clk); #1;
      cyc++;
    end
    checks++;
    if (got < 1000) begin errors++; $display("FAIL loop_timeout: got %0d beats expected 1000", got); end
    valid_i = 1'b0; sof_i = 1'b0; chain = 1'b0; d_ready_i = 1'b1;
  endtask

  task automatic test_async_reset;
    int unsigned key, d, expv;
    do_reset;
    valid_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      d = $urandom_range(0, 15);
      data_i = d[3:0];
      mbeat(m4, 4, key, m4);
      @(posedge clk); #1;
    end
    #3;
    rstn = 1'b0;
    #1;
    checks++;
    if (valid_o !== 1'b0 || lfsr_o !== 12'h14D || data_o !== 4'h0 || sof_o !== 1'b0)
      begin errors++; $display("FAIL areset_now: got v=%b l=%h d=%h s=%b expected 0 14d 0 0", valid_o, lfsr_o, data_o, sof_o); end
    @(posedge clk); #1;
    checks++;
    if (valid_o !== 1'b0 || lfsr_o !== 12'h14D)
      begin errors++; $display("FAIL areset_hold: got v=%b l=%h expected 0 14d", valid_o, lfsr_o); end
    rstn = 1'b1;
    m4 = SEED_M;
    data_i = 4'h0; sof_i = 1'b0;
`ifdef SCRAMBLER_PAR_BYPASS_EN
    bypass = 1'b1;
    mbeat(m4, 4, key, m4);
    @(posedge clk); #1;
    checks++;
    if (data_o !== 4'h0 || lfsr_o !== m4[11:0])
      begin errors++; $display("FAIL bypass_on: got d=%h l=%h expected 0 %h", data_o, lfsr_o, m4[11:0]); end
    bypass = 1'b0;
    mbeat(m4, 4, key, m4);
    @(posedge clk); #1;
    checks++;
    if (data_o !== key[3:0] || lfsr_o !== m4[11:0])
      begin errors++; $display("FAIL bypass_off: got d=%h l=%h expected %h %h", data_o, lfsr_o, key[3:0], m4[11:0]); end
`else
    mbeat(m4, 4, key, m4);
    expv = key;
    @(posedge clk); #1;
    checks++;
    if (valid_o !== 1'b1 || data_o !== expv[3:0] || data_o !== 4'h1 || lfsr_o !== m4[11:0])
      begin errors++; $display("FAIL areset_first: got v=%b d=%h l=%h expected 1 1 %h", valid_o, data_o, lfsr_o, m4[11:0]); end
`endif
    valid_i = 1'b0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset;
    test_stream;
    test_bit;
    test_backpressure;
    test_loopback;
    test_async_reset;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
